// File: rtl/rca_share_sched.sv
// ---------------------------------------------------------------------------
// rca_share_sched
//
// Purpose
//   Performs WIDTH-bit additions (a + b + cin) by time-multiplexing a single
//   4-bit ripple-carry adder, one nibble per clock, least significant nibble
//   first. Two requesters share the adder under round-robin arbitration. The
//   result is returned on a single port, tagged with the id of the requester
//   that issued the operation.
//
// Handshakes
//   Both ports use valid/ready. A transfer happens on a rising clock edge where
//   valid and ready are both high. A requester may hold valid for as long as it
//   likes; it is simply stalled while the adder is busy. The result port holds
//   res_sum/res_cout/res_id stable while res_valid is high, until the consumer
//   takes the result with res_ready.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   req_valid  in   2      bit k: requester k presents operands
//   req_ready  out  2      bit k: requester k is granted (IDLE only, one-hot)
//   req0_a/b   in   WIDTH  requester 0 operands
//   req1_a/b   in   WIDTH  requester 1 operands
//   req_cin    in   2      bit k: carry-in of requester k
//   res_valid  out  1      result available
//   res_ready  in   1      consumer accepts result
//   res_sum    out  WIDTH  (a + b + cin) mod 2^WIDTH
//   res_cout   out  1      carry out of bit WIDTH-1
//   res_id     out  1      requester that issued the result
//   busy       out  1      an operation is in progress or awaiting hand-off
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder shared by all nibble passes.
module rca_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    always_comb begin
        logic [4:0] c;
        c    = 5'b0;
        sum  = 4'b0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[4];
    end
endmodule

module rca_share_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic              last_grant;

    logic [1:0]        grant;
    logic              grant_id;
    logic              accept;
    logic              last_nib;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        nib_sum;
    logic              nib_cout;

    // Round-robin: a lone requester always wins; on contention the requester
    // that did not win last time is granted. last_grant resets to 1 so that
    // requester 0 wins the first contention after reset.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign grant_id  = grant[1];
    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign last_nib  = (idx == IDXW'(NIB - 1));

    assign nib_a = a_q[4*idx +: 4];
    assign nib_b = b_q[4*idx +: 4];

    rca_adder u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_nib)  state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            carry      <= 1'b0;
            last_grant <= 1'b1;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_id     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Operands are copied here so later changes on the
                        // request inputs cannot disturb the running add.
                        a_q        <= grant_id ? req1_a : req0_a;
                        b_q        <= grant_id ? req1_b : req0_b;
                        carry      <= req_cin[grant_id];
                        res_id     <= grant_id;
                        last_grant <= grant_id;
                        idx        <= '0;
                    end
                end
                RUN: begin
                    res_sum[4*idx +: 4] <= nib_sum;
                    carry               <= nib_cout;
                    if (last_nib) begin
                        res_cout <= nib_cout;
                        idx      <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_share_sched.sv
// ---------------------------------------------------------------------------
// tb_rca_share_sched
//
// Bench for rca_share_sched (WIDTH = 16). Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge. A reference model
// tracks, at transaction level, which operation is in flight (exp_q), how
// many cycles have passed since it was accepted, and which requester won the
// last arbitration. Directed scenarios add literal expectations, then a long
// randomized run exercises arbitration, stalls and wrap-around.
// ---------------------------------------------------------------------------
module tb_rca_share_sched;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [1:0]   req_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;
    logic         busy;

    int checks = 0;
    int errors = 0;

    rca_share_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each entry is {id, cout, sum} of an accepted operation not yet handed off.
    logic [W+1:0] exp_q[$];
    int           m_cnt     = 0;   // cycles elapsed since the accept edge
    logic         m_last    = 1'b1;
    int           n_results = 0;

    // Arbitration rule: lone requester wins, otherwise not the previous winner.
    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(posedge clk) begin
        logic [1:0]   g;
        logic [W:0]   full;
        if (rst) begin
            exp_q.delete();
            m_cnt  = 0;
            m_last = 1'b1;
        end else if (exp_q.size() == 0) begin
            g = model_grant(req_valid, m_last);
            if (g != 2'b00) begin
                if (g[1]) full = {1'b0, req1_a} + {1'b0, req1_b} + (W+1)'(req_cin[1]);
                else      full = {1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(req_cin[0]);
                exp_q.push_back({g[1], full});
                m_last = g[1];
                m_cnt  = 1;
            end
        end else if (m_cnt >= NIB + 1 && res_ready) begin
            void'(exp_q.pop_front());
            n_results++;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [1:0] e_rdy;
        logic       e_busy;
        logic       e_valid;
        if (!rst) begin
            e_busy  = (exp_q.size() != 0);
            e_valid = e_busy && (m_cnt >= NIB + 1);
            e_rdy   = e_busy ? 2'b00 : model_grant(req_valid, m_last);
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("res_valid", 32'(res_valid), 32'(e_valid));
            if (e_valid) begin
                chk("result{id,cout,sum}", 32'({res_id, res_cout, res_sum}), 32'(exp_q[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req_cin = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step(); step();
        rst = 1'b0;
    endtask

    // Present one operation from requester id (DUT must be idle), then wait
    // until res_valid. Returns at a falling edge with the result on the port.
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic rr, output int lat);
        logic found;
        step();
        res_ready = rr;
        req_valid = id ? 2'b10 : 2'b01;
        if (id) begin req1_a = a; req1_b = b; end
        else    begin req0_a = a; req0_b = b; end
        req_cin = id ? 2'b10 : 2'b00;
        if (cin) req_cin = req_cin | (id ? 2'b10 : 2'b01);
        step();
        // Scramble operand inputs after accept; the latched copy must be used.
        req_valid = 2'b00;
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        req_cin = 2'($urandom_range(0, 3));
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (res_valid) found = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("op_result_arrived", 32'(found), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         lat;
        int         got;
        int         cyc;
        int         start_res;
        logic [3:0] exp_ids;
        logic [W-1:0] held_sum;

        rst = 1'b1;
        res_ready = 1'b0;
        idle_inputs();
        step(); step(); step();

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_sum", 32'(res_sum), 32'd0);
        chk("rst_res_cout", 32'(res_cout), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;

        // 1: requester 0, basic add with a carry between nibbles
        do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b1, lat);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_sum", 32'(res_sum), 32'h2233);
        chk("t1_cout", 32'(res_cout), 32'd0);
        chk("t1_id", 32'(res_id), 32'd0);
        chk("t1_model_entry", 32'(exp_q[0]), 32'({1'b0, 1'b0, 16'h2233}));
        step();

        // 2: requester 1, carry-in ripples through every nibble and wraps
        do_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, lat);
        chk("t2_latency", 32'(lat), 32'd5);
        chk("t2_sum", 32'(res_sum), 32'h0000);
        chk("t2_cout", 32'(res_cout), 32'd1);
        chk("t2_id", 32'(res_id), 32'd1);
        step();

        // 3: both requesters valid continuously from reset -> 0,1,0,1
        do_reset();
        req_valid = 2'b11;
        req0_a = 16'h0101; req0_b = 16'h0202;
        req1_a = 16'h1000; req1_b = 16'h2000;
        res_ready = 1'b1;
        exp_ids = 4'b1010;  // bit i = expected id of result i
        got = 0;
        for (int i = 0; i < 100 && got < 4; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                chk("t3_id_seq", 32'(res_id), 32'(exp_ids[got]));
                got++;
            end
            step();
        end
        chk("t3_result_count", 32'(got), 32'd4);
        req_valid = 2'b00;
        step(); step(); step(); step(); step(); step(); step();

        // 4: consumer stalls for 10 cycles in DONE
        do_op(1'b0, 16'hABCD, 16'h1111, 1'b1, 1'b0, lat);
        held_sum = res_sum;
        chk("t4_sum", 32'(held_sum), 32'hBCDF);
        step();
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_sum", 32'(res_sum), 32'hBCDF);
            chk("t4_hold_id", 32'(res_id), 32'd0);
            chk("t4_ready_low", 32'(req_ready), 32'd0);
            step();
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        step(); step();

        // 5: reset during the second RUN cycle aborts the operation
        req_valid = 2'b10;
        req1_a = 16'h5555; req1_b = 16'h3333; req_cin = 2'b00;
        @(negedge clk);
        chk("t5_grant_req1", 32'(req_ready), 32'b10);
        step();            // first RUN cycle
        req_valid = 2'b00;
        step();            // second RUN cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_res_valid", 32'(res_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        step();
        req_valid = 2'b11;
        @(negedge clk);
        chk("t5_req0_first", 32'(req_ready), 32'b01);
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) step();

        // 6: randomized operations, random valids and consumer back-pressure
        start_res = n_results;
        cyc = 0;
        while (n_results < start_res + 1000 && cyc < 40000) begin
            step();
            cyc++;
            req_valid = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       begin req0_a = 16'hFFFF; req1_b = 16'hFFFF; end
                1:       begin req0_a = 16'h0000; req1_b = 16'h0000; end
                default: begin req0_a = W'($urandom); req1_b = W'($urandom); end
            endcase
            req0_b    = W'($urandom);
            req1_a    = W'($urandom);
            req_cin   = 2'($urandom_range(0, 3));
            res_ready = ($urandom_range(0, 3) != 0);
        end
        chk("t6_ops_completed", 32'(n_results - start_res >= 1000), 32'd1);

        req_valid = 2'b00;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
